xgmii_tx_scheduler: RTL and testbench

Sequences frames from the MAC TX stream onto the 32-bit XGMII interface that feeds the 64b/66b encoder. It inserts preamble/SFD, terminate and idle control characters, and enforces the minimum inter-packet gap (IPG). It aligns every /S/ to lane 0 of a 64-bit block and honours the encoder's pause backpressure. On upstream underrun it corrupts the frame and drains the remainder.

---
 rtl/xgmii_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_xgmii_tx_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_scheduler.sv
// XGMII TX scheduler: frames the MAC stream with preamble/SFD, /T/ and idles,
// keeps /S/ on lane 0 of a 64-bit block and enforces the IPG. Optional stats: XGMII_TX_SCHED_STATS_EN.
module xgmii_tx_scheduler #(
  parameter int IPG_BYTES  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] o_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
  output logic                  o_xgmii_valid,
  input  logic                  i_xgmii_pause
`ifdef XGMII_TX_SCHED_STATS_EN
  ,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_underrun_cnt
`endif
);

  localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;
  localparam logic [31:0] START_WORD = 32'h5555_55FB;
  localparam logic [31:0] SFD_WORD   = 32'hD555_5555;
  localparam logic [31:0] TERM_WORD  = 32'h0707_07FD;
  localparam logic [31:0] ERROR_WORD = 32'hFEFE_FEFE;
  localparam logic [4:0]  IPG_MIN    = 5'(IPG_BYTES);
  localparam logic [4:0]  IPG_SAT    = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE1, ST_PRE2, ST_DATA, ST_TERM, ST_IPG
  } state_t;

  state_t     state;
  logic       parity;
  logic       drop;
  logic [4:0] ipg_cnt;

  logic       advance;
  logic       accept;
  logic [5:0] ipg_sum;
  logic [4:0] ipg_inc;
  logic       partial;
  logic [31:0] last_word;
  logic [3:0]  last_ctrl;
  logic [4:0]  last_gap;

  assign advance       = !i_xgmii_pause;
  assign s_axis_tready = drop || (state == ST_DATA && advance);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign ipg_sum       = {1'b0, ipg_cnt} + 6'd4;
  assign ipg_inc       = (ipg_sum > 6'd31) ? IPG_SAT : ipg_sum[4:0];

  // Final beat with partial keep carries /T/ right after the last valid byte.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    partial   = 1'b1;
    last_word = s_axis_tdata;
    last_ctrl = 4'b0000;
    last_gap  = 5'd4;
    case (s_axis_tkeep)
      4'b0001: begin
        last_word = {8'h07, 8'h07, 8'hFD, s_axis_tdata[7:0]};
        last_ctrl = 4'b1110;
        last_gap  = 5'd3;
      end
      4'b0011: begin
        last_word = {8'h07, 8'hFD, s_axis_tdata[15:0]};
        last_ctrl = 4'b1100;
        last_gap  = 5'd2;
      end
      4'b0111: begin
        last_word = {8'hFD, s_axis_tdata[23:0]};
        last_ctrl = 4'b1000;
        last_gap  = 5'd1;
      end
      default: partial = 1'b0;
    endcase
  end

  // NOTE: asynchronous active-low reset; all sequential state uses non-blocking assignments.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      parity        <= 1'b0;
      drop          <= 1'b0;
      ipg_cnt       <= IPG_SAT;
      o_xgmii_txd   <= IDLE_WORD;
      o_xgmii_txc   <= 4'hF;
      o_xgmii_valid <= 1'b0;
    end else begin
      if (drop && accept && s_axis_tlast) drop <= 1'b0;
      if (advance) begin
        o_xgmii_valid <= 1'b1;
        parity        <= ~parity;
        case (state)
          ST_IDLE: begin
            o_xgmii_txd <= IDLE_WORD;
            o_xgmii_txc <= 4'hF;
            // The beat loaded now has parity 1, so /S/ on the next one is block-aligned.
            if (s_axis_tvalid && !drop && ipg_cnt >= IPG_MIN && parity) state <= ST_PRE1;
          end
          ST_PRE1: begin
            o_xgmii_txd <= START_WORD;
            o_xgmii_txc <= 4'b0001;
            state       <= ST_PRE2;
          end
          ST_PRE2: begin
            o_xgmii_txd <= SFD_WORD;
            o_xgmii_txc <= 4'b0000;
            state       <= ST_DATA;
          end
          ST_DATA: begin
            if (s_axis_tvalid) begin
              if (s_axis_tlast && partial) begin
                o_xgmii_txd <= last_word;
                o_xgmii_txc <= last_ctrl;
                ipg_cnt     <= last_gap;
                state       <= ST_IPG;
              end else begin
                o_xgmii_txd <= s_axis_tdata;
                o_xgmii_txc <= 4'b0000;
                if (s_axis_tlast) state <= ST_TERM;
              end
            end else begin
              o_xgmii_txd <= ERROR_WORD;
              o_xgmii_txc <= 4'hF;
              drop        <= 1'b1;
              state       <= ST_TERM;
            end
          end
          ST_TERM: begin
            o_xgmii_txd <= TERM_WORD;
            o_xgmii_txc <= 4'hF;
            ipg_cnt     <= 5'd4;
            state       <= ST_IPG;
          end
          ST_IPG: begin
            o_xgmii_txd <= IDLE_WORD;
            o_xgmii_txc <= 4'hF;
            ipg_cnt     <= ipg_inc;
            if (ipg_inc >= IPG_MIN) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef XGMII_TX_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_frame_cnt    <= '0;
      o_underrun_cnt <= '0;
    end else if (advance && state == ST_DATA) begin
      if (s_axis_tvalid && s_axis_tlast) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (!s_axis_tvalid) o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed bench for xgmii_tx_scheduler: framing, IPG/alignment, pause, underrun drain, reset.
module tb_xgmii_tx_scheduler;

  localparam logic [31:0] IDLE_W = 32'h0707_0707;
  localparam logic [31:0] S_W    = 32'h5555_55FB;
  localparam logic [31:0] SFD_W  = 32'hD555_5555;
  localparam logic [31:0] T_W    = 32'h0707_07FD;
  localparam logic [31:0] FE_W   = 32'hFEFE_FEFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [31:0] txd;
  logic [3:0]  txc;
  logic        xvalid;
  logic        pause;
`ifdef XGMII_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int failures = 0;

  xgmii_tx_scheduler #(.IPG_BYTES(12)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .o_xgmii_txd   (txd),
    .o_xgmii_txc   (txc),
    .o_xgmii_valid (xvalid),
    .i_xgmii_pause (pause)
`ifdef XGMII_TX_SCHED_STATS_EN
    ,
    .o_frame_cnt    (frame_cnt),
    .o_underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_txd,
                            input logic [3:0] e_txc, input logic e_rdy);
    check({tag, "_txd"}, txd, e_txd);
    check({tag, "_txc"}, {28'd0, txc}, {28'd0, e_txc});
    check({tag, "_rdy"}, {31'd0, tready}, {31'd0, e_rdy});
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v, input logic l);
    tdata  = d;
    tkeep  = k;
    tvalid = v;
    tlast  = l;
  endtask

  // One clock edge, then settle on the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pause = 1'b0;
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    expect_out("reset", IDLE_W, 4'hF, 1'b0);
    check("reset_valid", {31'd0, xvalid}, 32'd0);
`ifdef XGMII_TX_SCHED_STATS_EN
    check("reset_frames", {16'd0, frame_cnt}, 32'd0);
`endif

    // Frame 1: 8 bytes, full keep; starts right after reset on the 3rd beat.
    rst_n = 1'b1;
    drive(32'h0302_0100, 4'hF, 1'b1, 1'b0);
    step(); expect_out("f1_idle0", IDLE_W, 4'hF, 1'b0);
    check("valid_rise", {31'd0, xvalid}, 32'd1);
    step(); expect_out("f1_idle1", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f1_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f1_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f1_d0", 32'h0302_0100, 4'b0000, 1'b1);
    drive(32'h0706_0504, 4'hF, 1'b1, 1'b1);
    step(); expect_out("f1_d1", 32'h0706_0504, 4'b0000, 1'b0);
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    step(); expect_out("f1_term", T_W, 4'hF, 1'b0);

    // Frame 2 waits: TERM + 3 idle beats before its /S/ lands on parity 0.
    drive(32'hA3A2_A1A0, 4'hF, 1'b1, 1'b0);
    step(); expect_out("ipg1_a", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg1_b", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg1_c", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f2_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f2_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f2_d0", 32'hA3A2_A1A0, 4'b0000, 1'b1);
    drive(32'h00CC_BBAA, 4'b0111, 1'b1, 1'b1);
    step(); expect_out("f2_tpart", 32'hFDCC_BBAA, 4'b1000, 1'b0);

    // Frame 3 queued back-to-back: gap count 1 -> 13 after 3 idles, then parity wait.
    drive(32'h1122_3344, 4'hF, 1'b1, 1'b0);
    step(); expect_out("ipg2_a", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg2_b", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg2_c", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg2_d", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f3_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f3_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f3_d0", 32'h1122_3344, 4'b0000, 1'b1);

    // Pause for 3 cycles mid-DATA: outputs frozen, nothing accepted.
    pause = 1'b1;
    drive(32'h5566_7788, 4'hF, 1'b1, 1'b1);
    step(); expect_out("pause_a", 32'h1122_3344, 4'b0000, 1'b0);
    step(); expect_out("pause_b", 32'h1122_3344, 4'b0000, 1'b0);
    step(); expect_out("pause_c", 32'h1122_3344, 4'b0000, 1'b0);
    pause = 1'b0;
    step(); expect_out("f3_d1", 32'h5566_7788, 4'b0000, 1'b0);
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    step(); expect_out("f3_term", T_W, 4'hF, 1'b0);

    // Frame 4: underrun after the first beat, then drain the remainder.
    drive(32'hCAFE_0001, 4'hF, 1'b1, 1'b0);
    step(); expect_out("ipg3_a", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg3_b", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("ipg3_c", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f4_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f4_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f4_d0", 32'hCAFE_0001, 4'b0000, 1'b1);
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    step(); expect_out("f4_fe", FE_W, 4'hF, 1'b1);
    drive(32'hCAFE_0002, 4'hF, 1'b1, 1'b0);
    step(); expect_out("f4_term", T_W, 4'hF, 1'b1);
    drive(32'hCAFE_0003, 4'hF, 1'b1, 1'b1);
    step(); expect_out("f4_drained", IDLE_W, 4'hF, 1'b0);
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    step(); expect_out("ipg4_b", IDLE_W, 4'hF, 1'b0);
`ifdef XGMII_TX_SCHED_STATS_EN
    check("frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check("underrun_cnt", {16'd0, underrun_cnt}, 32'd1);
`endif

    // Frame 5: reset asserted during DATA.
    drive(32'hBEEF_0001, 4'hF, 1'b1, 1'b0);
    step(); expect_out("ipg4_c", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f5_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f5_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f5_d0", 32'hBEEF_0001, 4'b0000, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_out("midreset", IDLE_W, 4'hF, 1'b0);
    check("midreset_valid", {31'd0, xvalid}, 32'd0);
    @(negedge clk);

    // Frame 6 after release: clean start, ending on a 1-byte partial beat.
    rst_n = 1'b1;
    drive(32'h89AB_CDEF, 4'hF, 1'b1, 1'b0);
    step(); expect_out("f6_idle0", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f6_idle1", IDLE_W, 4'hF, 1'b0);
    step(); expect_out("f6_pre1", S_W, 4'b0001, 1'b0);
    step(); expect_out("f6_pre2", SFD_W, 4'b0000, 1'b1);
    step(); expect_out("f6_d0", 32'h89AB_CDEF, 4'b0000, 1'b1);
    drive(32'h0000_0044, 4'b0001, 1'b1, 1'b1);
    step(); expect_out("f6_tpart", 32'h0707_FD44, 4'b1110, 1'b0);
    drive(32'd0, 4'd0, 1'b0, 1'b0);
    step(); expect_out("f6_ipg", IDLE_W, 4'hF, 1'b0);
    check("f6_valid", {31'd0, xvalid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
